// File: rtl/encoder_8b10b_multilane.sv
// rtl/encoder_8b10b_multilane.sv - multi-lane 8b/10b encoder with per-lane running disparity
// Optional feature macro: ENCODER_8B10B_RD_FORCE_EN (adds rd_force_i / rd_force_val_i)
module encoder_8b10b_multilane #(
  parameter int LANES   = 4,
  parameter bit RD_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LANES*8-1:0]    data_i,
  input  logic [LANES-1:0]      k_i,
`ifdef ENCODER_8B10B_RD_FORCE_EN
  input  logic                  rd_force_i,
  input  logic [LANES-1:0]      rd_force_val_i,
`endif
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES*10-1:0]   symbol_o,
  output logic [LANES-1:0]      rd_o,
  output logic [LANES-1:0]      k_err_o
);

  // 5b/6b codes for RD-, written abcdei with 'a' in bit 5
  function automatic logic [5:0] enc6_rdm(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;
      5'd1:  return 6'b011101;
      5'd2:  return 6'b101101;
      5'd3:  return 6'b110001;
      5'd4:  return 6'b110101;
      5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;
      5'd7:  return 6'b111000;
      5'd8:  return 6'b111001;
      5'd9:  return 6'b100101;
      5'd10: return 6'b010101;
      5'd11: return 6'b110100;
      5'd12: return 6'b001101;
      5'd13: return 6'b101100;
      5'd14: return 6'b011100;
      5'd15: return 6'b010111;
      5'd16: return 6'b011011;
      5'd17: return 6'b100011;
      5'd18: return 6'b010011;
      5'd19: return 6'b110010;
      5'd20: return 6'b001011;
      5'd21: return 6'b101010;
      5'd22: return 6'b011010;
      5'd23: return 6'b111010;
      5'd24: return 6'b110011;
      5'd25: return 6'b100110;
      5'd26: return 6'b010110;
      5'd27: return 6'b110110;
      5'd28: return 6'b001110;
      5'd29: return 6'b101110;
      5'd30: return 6'b011110;
      default: return 6'b101011;
    endcase
  endfunction

  // 3b/4b codes for RD-, written fghj with 'f' in bit 3; alt7 selects the A7 form
  function automatic logic [3:0] enc4_rdm(input logic [2:0] y, input logic alt7);
    case (y)
      3'd0: return 4'b1011;
      3'd1: return 4'b1001;
      3'd2: return 4'b0101;
      3'd3: return 4'b1100;
      3'd4: return 4'b1101;
      3'd5: return 4'b1010;
      3'd6: return 4'b0110;
      default: return alt7 ? 4'b0111 : 4'b1110;
    endcase
  endfunction

  logic                 out_valid_q, out_valid_d;
  logic [LANES*10-1:0]  symbol_q, symbol_d;
  logic [LANES-1:0]     rd_q, rd_d;
  logic [LANES-1:0]     k_err_q, k_err_d;
  logic                 accept;

  wire  [LANES*10-1:0]  enc_symbol;
  wire  [LANES-1:0]     enc_rd;
  wire  [LANES-1:0]     enc_kerr;

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign symbol_o    = symbol_q;
  assign rd_o        = rd_q;
  assign k_err_o     = k_err_q;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [4:0] x;
    logic [2:0] y;
    logic       legal_k;
    logic       use_k;
    logic       rd_start;
    logic       rd_mid;
    logic       alt7;
    logic [5:0] c6;
    logic [3:0] c4;

    // Encode one lane: 6b sub-block from the start RD, 4b sub-block from the mid RD
    always_comb begin
      x       = data_i[8*n +: 5];
      y       = data_i[8*n+5 +: 3];
      legal_k = (x == 5'd28) ||
                ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
      use_k   = k_i[n] && legal_k;
`ifdef ENCODER_8B10B_RD_FORCE_EN
      rd_start = rd_force_i ? rd_force_val_i[n] : rd_q[n];
`else
      rd_start = rd_q[n];
`endif
      c6 = (use_k && (x == 5'd28)) ? 6'b001111 : enc6_rdm(x);
      // Unbalanced codes and the D.7 pair have a distinct RD+ form (bitwise complement)
      if (rd_start && (($countones(c6) != 3) || (c6 == 6'b111000))) c6 = ~c6;
      rd_mid = rd_start ^ ($countones(c6) != 3);
      alt7   = use_k ||
               (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
               ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
      c4 = enc4_rdm(y, alt7);
      if (rd_mid && (($countones(c4) != 2) || (y == 3'd3))) c4 = ~c4;
      // K28.y with balanced 4b codes flips polarity to keep the comma unique
      if (use_k && (x == 5'd28) && !rd_mid &&
          ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) c4 = ~c4;
    end

    assign enc_symbol[10*n +: 10] = {c4[0], c4[1], c4[2], c4[3],
                                     c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    assign enc_rd[n]   = rd_mid ^ ($countones(c4) != 2);
    assign enc_kerr[n] = k_i[n] && !legal_k;
  end

  // Output stage next state: load on accept, clear valid on drain, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    symbol_d    = symbol_q;
    rd_d        = rd_q;
    k_err_d     = k_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      symbol_d    = enc_symbol;
      rd_d        = enc_rd;
      k_err_d     = enc_kerr;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Output and running-disparity registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      symbol_q    <= '0;
      rd_q        <= {LANES{RD_INIT}};
      k_err_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      symbol_q    <= symbol_d;
      rd_q        <= rd_d;
      k_err_q     <= k_err_d;
    end
  end

endmodule
